// File: rtl/edge_mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter and its round-robin helper.
package edge_mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/edge_mem_port_arbiter_if.sv
// Requester-side and memory-side buses of the shared memory port.
interface edge_mem_port_arbiter_req_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_last,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_last,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface edge_mem_port_arbiter_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_we,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_we,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/edge_mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester above last_owner, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_vec,
  input  logic [ID_W-1:0]    i_last_owner,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic               o_gnt_any
);

  logic [ID_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest requester after last_owner wins.
  always_comb begin
    o_gnt_id  = '0;
    o_gnt_any = 1'b0;
    w_idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = ID_W'((int'(i_last_owner) + k) % NUM_REQ);
      if (i_req_vec[w_idx]) begin
        o_gnt_id  = w_idx;
        o_gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_mem_port_arbiter.sv
// Shares one memory port between NUM_REQ masters: round-robin grant, burst lock,
// one outstanding beat, and a response watchdog that returns an error on a dead slave.
module edge_mem_port_arbiter
  import edge_mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 3,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BURST = 8,
  parameter  int TIMEOUT   = 255,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  edge_mem_port_arbiter_req_if.slave  req_bus,
  edge_mem_port_arbiter_mem_if.master mem_bus,
  output logic                        o_grant_valid,
  output logic [ID_W-1:0]             o_grant_id,
  output logic                        o_timeout_irq,
  input  logic                        i_irq_clr
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [ID_W-1:0]    r_owner;
  logic [ID_W-1:0]    r_last_owner;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic [WD_W-1:0]    r_wd_cnt;
  logic               r_last;
  logic               r_irq;

  logic [ID_W-1:0]    w_arb_id;
  logic               w_arb_any;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic               w_owner_valid;
  logic               w_in_issue;
  logic               w_mem_valid;
  logic               w_accept;
  logic               w_rsp_fire;
  logic               w_wd_expire;
  logic               w_burst_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req_vec    (req_bus.req_valid),
    .i_last_owner (r_last_owner),
    .o_gnt_id     (w_arb_id),
    .o_gnt_any    (w_arb_any)
  );

  assign w_owner_oh    = NUM_REQ'(1) << r_owner;
  assign w_owner_valid = req_bus.req_valid[r_owner];
  assign w_in_issue    = (r_state == ARB_ISSUE);
  assign w_accept      = w_mem_valid & mem_bus.mem_ready;
  assign w_burst_done  = r_last || (r_beat_cnt == BEAT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_mem_valid = 1'b0;
    w_rsp_fire  = 1'b0;
    w_wd_expire = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_arb_any) w_state_nxt = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        w_mem_valid = w_owner_valid;
        if (!w_owner_valid)         w_state_nxt = ARB_IDLE;
        else if (mem_bus.mem_ready) w_state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        // A response arriving on the expiry cycle still counts as a good response.
        if (mem_bus.mem_rvalid) begin
          w_rsp_fire  = 1'b1;
          w_state_nxt = w_burst_done ? ARB_IDLE : ARB_ISSUE;
        end else if (r_wd_cnt == WD_LAST) begin
          w_wd_expire = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign mem_bus.mem_valid = w_mem_valid;
  assign mem_bus.mem_addr  = w_in_issue ? req_bus.req_addr[int'(r_owner)*ADDR_W +: ADDR_W] : '0;
  assign mem_bus.mem_wdata = w_in_issue ? req_bus.req_wdata[int'(r_owner)*DATA_W +: DATA_W] : '0;
  assign mem_bus.mem_we    = w_in_issue & req_bus.req_we[r_owner];

  assign req_bus.req_ready = w_accept ? w_owner_oh : '0;
  assign req_bus.rsp_valid = (w_rsp_fire | w_wd_expire) ? w_owner_oh : '0;
  assign req_bus.rsp_rdata = w_rsp_fire ? mem_bus.mem_rdata : '0;
  assign req_bus.rsp_err   = w_wd_expire;

  assign o_grant_valid = (r_state != ARB_IDLE);
  assign o_grant_id    = r_owner;
  assign o_timeout_irq = r_irq;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= '0;
      r_last_owner <= ID_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_wd_cnt     <= '0;
      r_last       <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_IDLE && w_arb_any) begin
        r_owner    <= w_arb_id;
        r_beat_cnt <= '0;
      end
      if (w_accept) begin
        r_last     <= req_bus.req_last[r_owner];
        r_beat_cnt <= r_beat_cnt + 1'b1;
        r_wd_cnt   <= '0;
      end else if (r_state == ARB_WAIT) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      // Any exit to IDLE (burst end, owner drop, abort) moves the rotation past the owner.
      if (r_state != ARB_IDLE && w_state_nxt == ARB_IDLE) r_last_owner <= r_owner;
      if (w_wd_expire)    r_irq <= 1'b1;
      else if (i_irq_clr) r_irq <= 1'b0;
    end
  end

endmodule
